phy_data_sync_filt: RTL and testbench

Multi-channel level synchronizer with per-channel glitch filtering and edge detection. It brings NUM_CH asynchronous control/status levels into the `clock` domain through a NUM_FLOPS-deep flop chain, then accepts a new level only after it has been stable for FILTER_CYCLES consecutive cycles. It reports accepted transitions as single-cycle rise/fall pulses and counts rejected glitches. It replaces single-bit dual-flop sync instances on PHY status inputs that are noisy or bouncy, such as signal-detect, PLL lock and pad strap levels.

---
 rtl/phy_data_sync_filt.sv | 101 ++++++++++
 tb/tb_phy_data_sync_filt.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_data_sync_filt.sv
// rtl/phy_data_sync_filt.sv - multi-channel level synchronizer with glitch filter and edge pulses
// Each channel runs through a flop chain, then a stability filter, then edge detection.
module phy_data_sync_filt #(
   parameter int                NUM_CH        = 4,
   parameter int                NUM_FLOPS     = 2,
   parameter logic [NUM_CH-1:0] RESET_VALUE   = {NUM_CH{1'b0}},
   parameter int                FILTER_CYCLES = 4,
   parameter int                GLITCH_CNT_W  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       d_in,
   input  logic                    filter_en,
   output logic [NUM_CH-1:0]       d_out,
   output logic [NUM_CH-1:0]       rise_pulse,
   output logic [NUM_CH-1:0]       fall_pulse,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

   localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [NUM_CH-1:0]       sync_q [NUM_FLOPS];
   logic [NUM_CH-1:0]       s_last;
   logic [CNT_W-1:0]        cnt_q  [NUM_CH];
   logic [CNT_W-1:0]        cnt_d  [NUM_CH];
   logic [NUM_CH-1:0]       d_out_d;
   logic [NUM_CH-1:0]       rise_d;
   logic [NUM_CH-1:0]       fall_d;
   logic [NUM_CH-1:0]       reject;
   logic                    any_reject;
   logic [GLITCH_CNT_W-1:0] glitch_d;

   // Plain flop chain: no logic between stages so metastability can settle.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_FLOPS; k++) begin
            sync_q[k] <= RESET_VALUE;
         end
      end else begin
         sync_q[0] <= d_in;
         for (int k = 1; k < NUM_FLOPS; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s_last = sync_q[NUM_FLOPS-1];

   // A mismatch run is accepted on its last required cycle; a run that ends early is a glitch.
   always_comb begin
      d_out_d = d_out;
      rise_d  = '0;
      fall_d  = '0;
      reject  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s_last[i] == d_out[i]) begin
            reject[i] = (cnt_q[i] != '0);
            cnt_d[i]  = '0;
         end else if (!filter_en || cnt_q[i] == CNT_LAST) begin
            d_out_d[i] = s_last[i];
            rise_d[i]  = s_last[i];
            fall_d[i]  = ~s_last[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign any_reject = |reject;

   always_comb begin
      glitch_d = glitch_cnt;
      if (any_reject && glitch_cnt != {GLITCH_CNT_W{1'b1}}) begin
         glitch_d = glitch_cnt + GLITCH_CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         d_out      <= RESET_VALUE;
         rise_pulse <= '0;
         fall_pulse <= '0;
         glitch_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         d_out      <= d_out_d;
         rise_pulse <= rise_d;
         fall_pulse <= fall_d;
         glitch_cnt <= glitch_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_phy_data_sync_filt.sv
// tb/tb_phy_data_sync_filt.sv - directed and randomized checks of phy_data_sync_filt
// Two instances share stimulus; the second has a 2-bit glitch counter for saturation.
`timescale 1ns/1ps
module tb_phy_data_sync_filt;

   localparam int             NCH = 4;
   localparam int             NF  = 2;
   localparam int             FC  = 4;
   localparam logic [NCH-1:0] RV  = 4'b0101;

   logic           clock     = 1'b0;
   logic           reset     = 1'b1;
   logic           filter_en = 1'b1;
   logic [NCH-1:0] d_in      = RV;

   logic [NCH-1:0] d_out_a, rise_a, fall_a;
   logic [NCH-1:0] d_out_b, rise_b, fall_b;
   logic [7:0]     glitch_a;
   logic [1:0]     glitch_b;

   int n_checks = 0;
   int n_fail   = 0;

   phy_data_sync_filt #(
      .NUM_CH(NCH), .NUM_FLOPS(NF), .RESET_VALUE(RV), .FILTER_CYCLES(FC), .GLITCH_CNT_W(8)
   ) dut_a (
      .clock(clock), .reset(reset), .d_in(d_in), .filter_en(filter_en),
      .d_out(d_out_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .glitch_cnt(glitch_a)
   );

   phy_data_sync_filt #(
      .NUM_CH(NCH), .NUM_FLOPS(NF), .RESET_VALUE(RV), .FILTER_CYCLES(FC), .GLITCH_CNT_W(2)
   ) dut_b (
      .clock(clock), .reset(reset), .d_in(d_in), .filter_en(filter_en),
      .d_out(d_out_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .glitch_cnt(glitch_b)
   );

   always #5 clock = ~clock;

   // Behavioural model: a delay queue for synchronization and a mismatch-run length per channel.
   logic [NCH-1:0] m_delay [$];
   logic [NCH-1:0] m_dout, m_rise, m_fall, m_s;
   int             m_run [NCH];
   int             m_glitch;
   int             m_feff;
   bit             m_rej;

   always @(posedge clock) begin
      if (reset) begin
         m_delay = {};
         for (int k = 0; k < NF; k++) m_delay.push_back(RV);
         m_dout   = RV;
         m_rise   = '0;
         m_fall   = '0;
         m_glitch = 0;
         for (int c = 0; c < NCH; c++) m_run[c] = 0;
      end else begin
         m_s    = m_delay[0];
         m_feff = filter_en ? FC : 1;
         m_rej  = 0;
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < NCH; c++) begin
            if (m_s[c] == m_dout[c]) begin
               if (m_run[c] > 0) m_rej = 1;
               m_run[c] = 0;
            end else if (m_run[c] + 1 >= m_feff) begin
               m_dout[c] = m_s[c];
               if (m_s[c]) m_rise[c] = 1'b1;
               else        m_fall[c] = 1'b1;
               m_run[c] = 0;
            end else begin
               m_run[c] = m_run[c] + 1;
            end
         end
         if (m_rej) m_glitch = m_glitch + 1;
         void'(m_delay.pop_front());
         m_delay.push_back(d_in);
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         d_in = 4'($urandom);
      end
      @(negedge clock);
      n_checks++;
      if (d_out_a !== RV) begin n_fail++; $display("FAIL reset_dout: got %b expected %b", d_out_a, RV); end
      n_checks++;
      if ((rise_a | fall_a) !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got rise %b fall %b expected 0", rise_a, fall_a); end
      n_checks++;
      if (glitch_a !== 8'd0) begin n_fail++; $display("FAIL reset_glitch: got %0d expected 0", glitch_a); end
      n_checks++;
      if (glitch_b !== 2'd0 || d_out_b !== RV) begin n_fail++; $display("FAIL reset_dut_b: got %b/%0d expected %b/0", d_out_b, glitch_b, RV); end
      d_in  = RV;
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         n_checks++;
         if ((rise_a | fall_a) !== 4'b0 || d_out_a !== RV) begin
            n_fail++;
            $display("FAIL reset_release: cycle %0d got dout %b rise %b fall %b expected %b 0 0", k, d_out_a, rise_a, fall_a, RV);
         end
      end
   endtask

   task automatic test_clean_edge();
      d_in = 4'b0000;
      repeat (12) @(negedge clock);
      n_checks++;
      if (d_out_a !== 4'b0000) begin n_fail++; $display("FAIL clean_settle: got %b expected 0000", d_out_a); end
      d_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         n_checks++;
         if (d_out_a[0] !== (k >= 6) || rise_a[0] !== (k == 6) || fall_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_rise: E+%0d got dout %b rise %b fall %b expected %b %b 0", k - 1, d_out_a[0], rise_a[0], fall_a[0], k >= 6, k == 6);
         end
      end
      d_in[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         n_checks++;
         if (d_out_a[0] !== (k < 6) || fall_a[0] !== (k == 6) || rise_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_fall: E+%0d got dout %b fall %b rise %b expected %b %b 0", k - 1, d_out_a[0], fall_a[0], rise_a[0], k < 6, k == 6);
         end
      end
   endtask

   task automatic test_glitch();
      int g0;
      int n_rise;
      int n_fall;
      g0 = m_glitch;
      d_in[2] = 1'b1;
      repeat (3) @(negedge clock);
      d_in[2] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         n_checks++;
         if (d_out_a[2] !== 1'b0 || rise_a[2] !== 1'b0 || fall_a[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_short: cycle %0d got dout %b rise %b fall %b expected 0 0 0", k, d_out_a[2], rise_a[2], fall_a[2]);
         end
      end
      n_checks++;
      if (glitch_a !== 8'(g0 + 1)) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", glitch_a, g0 + 1); end
      n_rise = 0;
      n_fall = 0;
      d_in[2] = 1'b1;
      repeat (4) @(negedge clock);
      d_in[2] = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         n_rise += int'(rise_a[2]);
         n_fall += int'(fall_a[2]);
      end
      n_checks++;
      if (n_rise != 1 || n_fall != 1) begin n_fail++; $display("FAIL glitch_accept4: got %0d rises %0d falls expected 1 1", n_rise, n_fall); end
      n_checks++;
      if (glitch_a !== 8'(g0 + 1)) begin n_fail++; $display("FAIL glitch_unchanged: got %0d expected %0d", glitch_a, g0 + 1); end
   endtask

   task automatic test_simultaneous();
      int g0;
      int n_both;
      int n_single;
      g0 = m_glitch;
      d_in[1] = 1'b1;
      d_in[3] = 1'b1;
      repeat (2) @(negedge clock);
      d_in[1] = 1'b0;
      d_in[3] = 1'b0;
      repeat (8) @(negedge clock);
      n_checks++;
      if (glitch_a !== 8'(g0 + 1)) begin n_fail++; $display("FAIL simul_glitch: got %0d expected %0d", glitch_a, g0 + 1); end
      n_both   = 0;
      n_single = 0;
      d_in[1:0] = 2'b11;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (rise_a[1:0] == 2'b11) n_both++;
         else if (rise_a[1:0] != 2'b00) n_single++;
      end
      n_checks++;
      if (n_both != 1 || n_single != 0) begin n_fail++; $display("FAIL simul_rise: got %0d joint %0d split expected 1 0", n_both, n_single); end
      d_in = 4'b0000;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_bypass_saturation();
      int g0;
      filter_en = 1'b0;
      d_in[0] = 1'b1;
      @(negedge clock);
      d_in[0] = 1'b0;
      @(negedge clock);
      n_checks++;
      if (d_out_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_early: got dout %b rise %b expected 0 0", d_out_a[0], rise_a[0]); end
      @(negedge clock);
      n_checks++;
      if (d_out_a[0] !== 1'b1 || rise_a[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_rise: got dout %b rise %b expected 1 1", d_out_a[0], rise_a[0]); end
      @(negedge clock);
      n_checks++;
      if (d_out_a[0] !== 1'b0 || fall_a[0] !== 1'b1 || rise_a[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_fall: got dout %b fall %b rise %b expected 0 1 0", d_out_a[0], fall_a[0], rise_a[0]);
      end
      filter_en = 1'b1;
      repeat (6) @(negedge clock);
      g0 = m_glitch;
      repeat (5) begin
         d_in[3] = 1'b1;
         @(negedge clock);
         d_in[3] = 1'b0;
         repeat (6) @(negedge clock);
      end
      n_checks++;
      if (glitch_b !== 2'd3) begin n_fail++; $display("FAIL sat_glitch_b: got %0d expected 3", glitch_b); end
      n_checks++;
      if (glitch_a !== 8'(g0 + 5)) begin n_fail++; $display("FAIL sat_glitch_a: got %0d expected %0d", glitch_a, g0 + 5); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         @(negedge clock);
         n_checks++;
         if (d_out_a !== m_dout || d_out_b !== m_dout) begin
            n_fail++;
            $display("FAIL rand_dout: cycle %0d got %b/%b expected %b", k, d_out_a, d_out_b, m_dout);
         end
         n_checks++;
         if (rise_a !== m_rise || fall_a !== m_fall || rise_b !== m_rise || fall_b !== m_fall) begin
            n_fail++;
            $display("FAIL rand_pulse: cycle %0d got rise %b fall %b expected %b %b", k, rise_a, fall_a, m_rise, m_fall);
         end
         n_checks++;
         if (glitch_a !== 8'(sat(m_glitch, 255)) || glitch_b !== 2'(sat(m_glitch, 3))) begin
            n_fail++;
            $display("FAIL rand_glitch: cycle %0d got %0d/%0d expected %0d", k, glitch_a, glitch_b, m_glitch);
         end
         if ($urandom_range(2, 0) == 0) d_in = 4'($urandom);
         if ($urandom_range(39, 0) == 0) filter_en = ~filter_en;
      end
      filter_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      d_in = RV;
      repeat (12) @(negedge clock);
      d_in = 4'b0111;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (d_out_a !== RV || (rise_a | fall_a) !== 4'b0 || glitch_a !== 8'd0) begin
         n_fail++;
         $display("FAIL midrst_state: got dout %b rise %b fall %b glitch %0d expected %b 0 0 0", d_out_a, rise_a, fall_a, glitch_a, RV);
      end
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         n_checks++;
         if (d_out_a[1] !== (k >= 6) || rise_a[1] !== (k == 6) || glitch_a !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_refilter: R+%0d got dout %b rise %b glitch %0d expected %b %b 0", k, d_out_a[1], rise_a[1], glitch_a, k >= 6, k == 6);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_edge();
      test_glitch();
      test_simultaneous();
      test_bypass_saturation();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
